// File: rtl/q2_memio.sv
// ---------------------------------------------------------------------------
// q2_memio : 4096x12 word RAM on a tri-state CPU bus, optional memory-mapped
//            UART transmitter enabled by macro Q2_MEMIO_UART_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module q2_memio #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [11:0] TX_ADDR      = 12'hFFF,
    parameter logic [11:0] STAT_ADDR    = 12'hFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] abus,
    inout  wire  [11:0] dbus,
    input  logic        rdm,
    input  logic        wrm,
    output logic        txd,
    output logic        tx_busy
);
    logic [11:0] mem_q [0:4095];
    logic        wrm_q;
    logic        wr_ev;
    logic        ram_sel;
    logic [11:0] rd_data;

    assign wr_ev = wrm & ~wrm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wrm_q <= 1'b0;
        else      wrm_q <= wrm;
    end

    // RAM contents survive reset; rst gating only suppresses strobes seen during it.
    always_ff @(posedge clk) begin
        if (rst && wr_ev && ram_sel) mem_q[abus] <= dbus;
    end

    assign dbus = (rdm && !wrm) ? rd_data : 12'hzzz;

`ifdef Q2_MEMIO_UART_EN
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam logic [11:0] BIT_LAST = 12'(CLKS_PER_BIT - 1);

    state_t      state_q;
    logic [11:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        txd_q, busy_q, ovr_q, rdm_q;
    logic        is_tx, is_stat, tx_wr, bit_done, frame_end, tx_accept, stat_rd_edge;

    assign is_tx        = (abus == TX_ADDR);
    assign is_stat      = (abus == STAT_ADDR);
    assign ram_sel      = ~(is_tx | is_stat);
    assign tx_wr        = wr_ev & is_tx;
    assign bit_done     = (baud_q == 12'd0);
    assign frame_end    = (state_q == S_STOP) && bit_done;
    // A write landing on the final STOP cycle chains straight into the next frame.
    assign tx_accept    = tx_wr && ((state_q == S_IDLE) || frame_end);
    assign stat_rd_edge = rdm & ~rdm_q & is_stat;

    always_comb begin
        rd_data = mem_q[abus];
        if (is_stat)    rd_data = {10'b0, ovr_q, busy_q};
        else if (is_tx) rd_data = 12'h000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= 12'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rdm_q   <= 1'b0;
        end else begin
            rdm_q <= rdm;
            if (tx_wr && !tx_accept) ovr_q <= 1'b1;
            else if (stat_rd_edge)   ovr_q <= 1'b0;

            case (state_q)
                S_IDLE: ;
                S_START: begin
                    if (bit_done) begin
                        state_q <= S_DATA;
                        baud_q  <= BIT_LAST;
                        bit_q   <= 3'd0;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q - 12'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_q <= BIT_LAST;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 12'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q - 12'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (tx_accept) begin
                state_q <= S_START;
                baud_q  <= BIT_LAST;
                bit_q   <= 3'd0;
                shift_q <= dbus[7:0];
                txd_q   <= 1'b0;
                busy_q  <= 1'b1;
            end
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
`else
    assign ram_sel = 1'b1;
    assign rd_data = mem_q[abus];
    assign txd     = 1'b1;
    assign tx_busy = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_q2_memio.sv
// ---------------------------------------------------------------------------
// tb_q2_memio : scoreboard bench for q2_memio (RAM path always, UART path
//               when Q2_MEMIO_UART_EN is defined).                 Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_q2_memio;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] abus = 12'h000;
    logic [11:0] tb_d = 12'h000;
    logic        tb_oe = 1'b0;
    logic        rdm = 1'b0;
    logic        wrm = 1'b0;
    logic        sample = 1'b0;
    wire  [11:0] dbus;
    wire         txd;
    wire         tx_busy;

    assign dbus = tb_oe ? tb_d : 12'hzzz;
    // Undriven bus floats to all-ones so a released bus is observable.
    pullup pu_dbus (dbus);

    always #5 clk = ~clk;

    q2_memio #(.CLKS_PER_BIT(N), .TX_ADDR(12'hFFF), .STAT_ADDR(12'hFFE)) dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus(dbus),
        .rdm(rdm), .wrm(wrm), .txd(txd), .tx_busy(tx_busy)
    );

    typedef struct {
        string       name;
        logic [11:0] v;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input string name, input logic [11:0] v);
        rd_exp_t e;
        e.name = name;
        e.v    = v;
        rd_q.push_back(e);
    endtask

    // Bus monitor: compares dbus whenever a sampled bus cycle is presented.
    always @(negedge clk) begin : rd_mon
        rd_exp_t e;
        if (sample) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no bus sample", dbus);
            end else begin
                e = rd_q.pop_front();
                check(e.name, dbus, e.v);
            end
        end
    end

    // Serial monitor: reassembles each frame from mid-bit samples of txd.
    initial begin : tx_mon
        int         c;
        logic [9:0] fr;
        logic [7:0] e;
        forever begin
            do @(negedge clk); while (tx_busy !== 1'b1);
            c  = 0;
            fr = '0;
            while (tx_busy === 1'b1 && c < 12 * N) begin
                if ((c % N) == 1 && (c / N) < 10) fr[c / N] = txd;
                c++;
                @(negedge clk);
            end
            if (rst) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got frame %b expected none", fr);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_frame", {2'b00, fr}, {2'b00, 1'b1, e, 1'b0});
                    check("tx_busy_len", 12'(c), 12'(10 * N));
                end
            end
        end
    end

    task automatic wr(input logic [11:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        abus = a; tb_d = d; tb_oe = 1'b1; wrm = 1'b1;
        @(posedge clk); #1;
        wrm = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [11:0] exp);
        @(posedge clk); #1;
        abus = a; rdm = 1'b1; sample = 1'b1;
        push_rd(name, exp);
        @(posedge clk); #1;
        rdm = 1'b0; sample = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        cycles(3); #1;
        check("rst_txd", 12'(txd), 12'h001);
        check("rst_busy", 12'(tx_busy), 12'h000);
        rst = 1'b1;

        wr(12'h123, 12'hA5C);
        rd("ram_123", 12'h123, 12'hA5C);
        @(posedge clk); #1;
        sample = 1'b1;
        push_rd("bus_z", 12'hFFF);
        @(posedge clk); #1;
        sample = 1'b0;

        wr(12'h000, 12'h001);
        wr(12'hFFD, 12'hEDC);
        rd("ram_000", 12'h000, 12'h001);
        rd("ram_ffd", 12'hFFD, 12'hEDC);

        // Both strobes high behaves as a write.
        @(posedge clk); #1;
        abus = 12'h010; tb_d = 12'h456; tb_oe = 1'b1; wrm = 1'b1; rdm = 1'b1;
        @(posedge clk); #1;
        wrm = 1'b0; rdm = 1'b0; tb_oe = 1'b0;
        rd("rdwr_both", 12'h010, 12'h456);

        // Held strobe with changing data: only the first cycle writes.
        @(posedge clk); #1;
        abus = 12'h020; tb_d = 12'h111; tb_oe = 1'b1; wrm = 1'b1;
        @(posedge clk); #1;
        tb_d = 12'h222;
        cycles(3); #1;
        wrm = 1'b0; tb_oe = 1'b0;
        rd("ram_once", 12'h020, 12'h111);

        // Strobes during reset are ignored; a strobe held across release writes once.
        wr(12'h030, 12'h0AB);
        @(posedge clk); #1;
        rst = 1'b0; abus = 12'h030; tb_d = 12'h333; tb_oe = 1'b1; wrm = 1'b1;
        cycles(2); #1;
        abus = 12'h031; tb_d = 12'h3C3;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        wrm = 1'b0; tb_oe = 1'b0;
        rd("rst_ignored", 12'h030, 12'h0AB);
        rd("rst_first_edge", 12'h031, 12'h3C3);

`ifndef Q2_MEMIO_UART_EN
        wr(12'hFFF, 12'h777);
        rd("plain_fff", 12'hFFF, 12'h777);
        wr(12'hFFE, 12'h123);
        rd("plain_ffe", 12'hFFE, 12'h123);
        cycles(5); #1;
        check("plain_txd", 12'(txd), 12'h001);
        check("plain_busy", 12'(tx_busy), 12'h000);
`else
        rd("tx_reads_zero", 12'hFFF, 12'h000);
        rd("stat_idle", 12'hFFE, 12'h000);

        tx_q.push_back(8'h41);
        wr(12'hFFF, 12'hF41);
        cycles(45);

        tx_q.push_back(8'h55);
        wr(12'hFFF, 12'h055);
        cycles(5);
        wr(12'hFFF, 12'h0AA);
        rd("stat_ovr", 12'hFFE, 12'h003);
        cycles(45);
        rd("stat_clr", 12'hFFE, 12'h000);

        tx_q.push_back(8'h3C);
        @(posedge clk); #1;
        abus = 12'hFFF; tb_d = 12'h03C; tb_oe = 1'b1; wrm = 1'b1;
        cycles(20); #1;
        wrm = 1'b0; tb_oe = 1'b0;
        cycles(30);
        rd("stat_single", 12'hFFE, 12'h000);

        // Abort in DATA while bit1 of 0x3C (a zero) is on the line.
        wr(12'hFFF, 12'h03C);
        cycles(8); #3;
        check("pre_rst_txd", 12'(txd), 12'h000);
        rst = 1'b0;
        #1;
        check("abort_txd", 12'(txd), 12'h001);
        check("abort_busy", 12'(tx_busy), 12'h000);
        cycles(2); #1;
        rst = 1'b1;
        tx_q.push_back(8'h7E);
        wr(12'hFFF, 12'h07E);
        cycles(45);
        rd("stat_after_abort", 12'hFFE, 12'h000);
`endif

        cycles(5);
        check("rd_q_empty", 12'(rd_q.size()), 12'h000);
        check("tx_q_empty", 12'(tx_q.size()), 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/q2_memio.md
Q2_MEMIO -- requirements
Module: q2_memio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit (range 2..4095).
REQ-002 SHALL have parameter TX_ADDR, default 12'hFFF, meaning the UART transmit data address.
REQ-003 SHALL have parameter STAT_ADDR, default 12'hFFE, meaning the UART status address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port abus, input, 12 bits: word address from the CPU.
REQ-007 SHALL have port dbus, inout, 12 bits: data bus, driven only during reads, otherwise high-Z.
REQ-008 SHALL have port rdm, input, 1 bit: memory read strobe, active-high level.
REQ-009 SHALL have port wrm, input, 1 bit: memory write strobe, active-high level.
REQ-010 SHALL have port txd, output, 1 bit: UART serial output, idle high.
REQ-011 SHALL have port tx_busy, output, 1 bit: the transmitter is shifting a frame.

Function
REQ-012 SHALL implement a 4096 x 12 word store addressed by abus; contents are not cleared by reset.
REQ-013 SHALL perform each write once per strobe: write event = wrm high this cycle and low the previous cycle (registered wrm_q).
REQ-014 SHALL store dbus into word abus on a write event unless abus equals TX_ADDR or STAT_ADDR (UART enabled).
REQ-015 SHALL drive dbus combinationally while rdm=1 and wrm=0; RAM word at abus, or the status word at STAT_ADDR.
REQ-016 SHALL define the status word as bits [11:2]=0, bit1=overrun, bit0=tx_busy; a read of TX_ADDR SHALL return 12'h000.
REQ-017 SHALL treat rdm and wrm high together as a write only, with dbus left at high-Z.
REQ-018 SHALL run a transmitter FSM with states IDLE -> START -> DATA -> STOP -> IDLE.
REQ-019 SHALL, in IDLE on a write event at TX_ADDR, latch dbus[7:0], enter START and set tx_busy in the following cycle; dbus[11:8] are ignored.
REQ-020 SHALL hold each state for exactly CLKS_PER_BIT cycles; txd is 0 in START, the LSB-first data bits in DATA (8 bits) and 1 in STOP and IDLE.
REQ-021 SHALL clear tx_busy on the STOP-to-IDLE transition; a frame occupies 10*CLKS_PER_BIT cycles.
REQ-022 SHALL drop a write event at TX_ADDR while tx_busy=1, leave the frame in progress undisturbed, and set overrun.
REQ-023 SHALL clear overrun on the rising edge of rdm (rdm high, previous rdm low) at STAT_ADDR; a set and a clear in the same cycle SHALL leave overrun set.
REQ-024 SHALL accept a write event at TX_ADDR in the same cycle the FSM returns to IDLE, starting the next frame back-to-back.
REQ-025 SHALL use a baud counter that reloads at every state entry; the counter SHALL NOT wrap or count in IDLE.

Reset
REQ-026 SHALL, while rst=0, force the FSM to IDLE, txd=1, tx_busy=0, overrun=0, wrm_q=0, rdm_q=0 and the baud and bit counters to 0.
REQ-027 SHALL abort a frame in progress at reset assertion, with txd returning to 1 immediately (asynchronously).
REQ-028 SHALL ignore strobes during reset and act on the first write edge seen after rst rises.

Configuration
REQ-029 SHALL include the UART (REQ-018..025, status word, address decode) only when macro Q2_MEMIO_UART_EN is defined.
REQ-030 SHALL, without Q2_MEMIO_UART_EN, treat TX_ADDR and STAT_ADDR as ordinary RAM, tie txd=1 and tie tx_busy=0.

Verification
REQ-031 SHALL check the RAM path: write 12'hA5C to 12'h123, then read 12'h123 -> dbus=12'hA5C; with rdm=0, dbus SHALL be Z.
REQ-032 SHALL check TX framing with CLKS_PER_BIT=4: write 12'hF41 to 12'hFFF -> txd sequence 0,1,0,0,0,0,0,1,0,1 with 4 cycles per bit; tx_busy high for 40 cycles.
REQ-033 SHALL check overrun: write 12'h055 to 12'hFFF, then write 12'h0AA while busy -> only 0x55 is transmitted; status reads 12'h003, and a second read after the frame ends returns 12'h000.
REQ-034 SHALL check single-write-per-strobe: hold wrm high for 20 cycles at 12'hFFF with UART idle -> exactly one frame and overrun=0.
REQ-035 SHALL check reset mid-frame: rst=0 during DATA -> txd=1 and tx_busy=0 at once; after release, a write of 12'h07E sends a clean frame.
REQ-036 SHALL check the build without Q2_MEMIO_UART_EN: write 12'h777 to 12'hFFF, then read -> 12'h777; txd stays 1.
